// File: rtl/lane_sprite_ctrl.sv
// lane_sprite_ctrl
//   Per-lane game-object controller. Owns one bullet and one zombie in a
//   single 120-pixel lane. Both objects advance on a free-running movement
//   tick. Collisions are tested on tick cycles only.
//
//   Optional build macro: AUTO_FIRE_EN. When it is defined, the plant
//   launches a bullet by itself whenever a live, unbreached zombie is
//   in the lane. The fire input is OR-ed in with that condition.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   fire           bullet launch request (level or pulse)
//   spawn          zombie spawn request
//   plant_present  a plant occupies the lane; launches need it
//   position, pos  bullet offset (drawn at x=120+position), bullet active
//   gpos, gstart   zombie offset (drawn at x=520-gpos), zombie active
//   hit, kill      one-cycle pulses on a strike / on the zombie's death
//   breach         sticky lane-lost flag, cleared only by rst
module lane_sprite_ctrl #(
  parameter int TICK_DIV     = 1000000,
  parameter int BULLET_STEP  = 4,
  parameter int ZOMBIE_STEP  = 1,
  parameter int BULLET_MAX   = 500,
  parameter int ZOMBIE_LIMIT = 280,
  parameter int ZOMBIE_HP    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fire,
  input  logic        spawn,
  input  logic        plant_present,
  output logic [10:0] position,
  output logic        pos,
  output logic [10:0] gpos,
  output logic        gstart,
  output logic        hit,
  output logic        kill,
  output logic        breach
);

  localparam int CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HPW = $clog2(ZOMBIE_HP + 1);
  localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [11:0]    B_STEP    = 12'(BULLET_STEP);
  localparam logic [11:0]    B_MAX     = 12'(BULLET_MAX);
  localparam logic [11:0]    Z_STEP    = 12'(ZOMBIE_STEP);
  localparam logic [11:0]    Z_LIM     = 12'(ZOMBIE_LIMIT);
  // The bullet's right edge is 139+position and the zombie's left edge is
  // 520-gpos. They touch once position+gpos >= 381.
  localparam logic [11:0]    COLL_SUM  = 12'd381;

  typedef enum logic       {B_IDLE, B_FLY} b_state_t;
  typedef enum logic [1:0] {Z_IDLE, Z_WALK, Z_BREACH} z_state_t;

  b_state_t       b_st;
  z_state_t       z_st;
  logic [CW-1:0]  tick_cnt;
  logic [HPW-1:0] hp;

  logic        tick, coll, launch;
  logic [11:0] b_next, z_next;

  assign tick   = (tick_cnt == TICK_LAST);
  assign b_next = {1'b0, position} + B_STEP;
  assign z_next = {1'b0, gpos} + Z_STEP;
  // Only a walking zombie can be struck. A breached zombie stays drawn
  // but is out of play.
  assign coll   = tick && (b_st == B_FLY) && (z_st == Z_WALK) &&
                  (({1'b0, position} + {1'b0, gpos}) >= COLL_SUM);

`ifdef AUTO_FIRE_EN
  assign launch = plant_present && (fire || (gstart && !breach));
`else
  assign launch = plant_present && fire;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      b_st     <= B_IDLE;
      z_st     <= Z_IDLE;
      hp       <= HPW'(ZOMBIE_HP);
      position <= '0;
      pos      <= 1'b0;
      gpos     <= '0;
      gstart   <= 1'b0;
      hit      <= 1'b0;
      kill     <= 1'b0;
      breach   <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
      hit      <= 1'b0;
      kill     <= 1'b0;

      // Bullet. A launch on a tick cycle wins, and the bullet does not
      // move on that tick.
      case (b_st)
        B_IDLE: if (launch) begin
          b_st     <= B_FLY;
          position <= '0;
          pos      <= 1'b1;
        end
        B_FLY: if (coll || (tick && (b_next > B_MAX))) begin
          b_st     <= B_IDLE;
          position <= '0;
          pos      <= 1'b0;
        end else if (tick) begin
          position <= b_next[10:0];
        end
        default: b_st <= B_IDLE;
      endcase

      // Zombie. On a tick, a collision wins over movement and breach.
      case (z_st)
        Z_IDLE: if (spawn) begin
          z_st   <= Z_WALK;
          gpos   <= '0;
          hp     <= HPW'(ZOMBIE_HP);
          gstart <= 1'b1;
        end
        Z_WALK: if (coll) begin
          hit <= 1'b1;
          hp  <= hp - HPW'(1);
          if (hp == HPW'(1)) begin
            kill   <= 1'b1;
            z_st   <= Z_IDLE;
            gstart <= 1'b0;
            gpos   <= '0;
          end
        end else if (tick) begin
          if (z_next >= Z_LIM) begin
            gpos   <= Z_LIM[10:0];
            z_st   <= Z_BREACH;
            breach <= 1'b1;
          end else begin
            gpos <= z_next[10:0];
          end
        end
        Z_BREACH: ;  // frozen until reset
        default: z_st <= Z_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_sprite_ctrl.sv
module tb_lane_sprite_ctrl;
  localparam int TD = 4, BS = 4, ZS = 1, BM = 500, ZL = 280, HP = 3;

  logic        clk = 1'b0, rst = 1'b1, fire = 1'b0, spawn = 1'b0, plant_present = 1'b0;
  logic [10:0] position, gpos;
  logic        pos, gstart, hit, kill, breach;

  always #5 clk = ~clk;

  lane_sprite_ctrl #(.TICK_DIV(TD), .BULLET_STEP(BS), .ZOMBIE_STEP(ZS),
                     .BULLET_MAX(BM), .ZOMBIE_LIMIT(ZL), .ZOMBIE_HP(HP)) dut (
    .clk(clk), .rst(rst), .fire(fire), .spawn(spawn), .plant_present(plant_present),
    .position(position), .pos(pos), .gpos(gpos), .gstart(gstart),
    .hit(hit), .kill(kill), .breach(breach));

  int n_cmp = 0, n_err = 0;
  bit armed = 0;

  // Game-level model: phase of the tick counter, the bullet, and the zombie
  // (0 absent, 1 walking, 2 breached), plus the pulse outputs.
  int m_cnt, m_bact, m_pos, m_z, m_gpos, m_hp, m_hit, m_kill;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit f, input bit s, input bit p);
    bit tick, coll, go;
    if (r) begin
      m_cnt = 0; m_bact = 0; m_pos = 0; m_z = 0; m_gpos = 0;
      m_hp = HP; m_hit = 0; m_kill = 0;
      return;
    end
    tick  = (m_cnt == TD - 1);
    m_cnt = (m_cnt + 1) % TD;
    coll  = tick && m_bact == 1 && m_z == 1 && (m_pos + m_gpos >= 381);
`ifdef AUTO_FIRE_EN
    go = p && (f || m_z == 1);
`else
    go = p && f;
`endif
    m_hit = 0; m_kill = 0;
    if (m_bact == 0) begin
      if (go) begin m_bact = 1; m_pos = 0; end
    end else if (coll || (tick && m_pos + BS > BM)) begin
      m_bact = 0; m_pos = 0;
    end else if (tick) m_pos += BS;

    if (m_z == 0) begin
      if (s) begin m_z = 1; m_gpos = 0; m_hp = HP; end
    end else if (m_z == 1) begin
      if (coll) begin
        m_hit = 1; m_hp--;
        if (m_hp == 0) begin m_kill = 1; m_z = 0; m_gpos = 0; end
      end else if (tick) begin
        if (m_gpos + ZS >= ZL) begin m_gpos = ZL; m_z = 2; end
        else m_gpos += ZS;
      end
    end
  endtask

  // Each cycle: compare the outputs against the model at negedge, drive the
  // inputs, advance the model across the coming edge, then resume 1ns later.
  task automatic step(input bit r, input bit f, input bit s, input bit p);
    logic [25:0] got, exp;
    @(negedge clk);
    if (armed) begin
      got = {position, pos, gpos, gstart, hit, kill, breach};
      exp = {11'(m_pos), m_bact[0], 11'(m_gpos), (m_z != 0), m_hit[0], m_kill[0], (m_z == 2)};
      check("cycle", int'(got), int'(exp));
    end
    rst = r; fire = f; spawn = s; plant_present = p;
    model_edge(r, f, s, p);
    if (r) armed = 1;
    @(posedge clk); #1;
  endtask

  // Run until n movement ticks have taken effect.
  task automatic step_ticks(input int n, input bit p);
    int k = 0;
    while (k < n) begin
      if (m_cnt == TD - 1) k++;
      step(0, 0, 0, p);
    end
  endtask

  task automatic align(input bit p);
    for (int i = 0; i < TD && m_cnt != 0; i++) step(0, 0, 0, p);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1, 0, 0, 0);
  endtask

  initial begin
    int hits, kills;
    // Reset and the plant_present gate.
    do_reset(2);
    step(0, 0, 0, 0);
    check("reset_outputs", int'({position, pos, gpos, gstart, hit, kill, breach}), 0);
    step(0, 1, 0, 0);
    check("fire_no_plant", int'(pos), 0);

    // Bullet flight and silent retire.
    align(1);
    step(0, 1, 0, 1);
    check("launch_pos", int'(pos), 1);
    check("launch_position", int'(position), 0);
    step_ticks(10, 1);
    check("flight_10", int'(position), 40);
    step_ticks(115, 1);
    check("flight_125", int'(position), 500);
    check("flight_125_act", int'(pos), 1);
    step_ticks(1, 1);
    check("retire", int'({position, pos}), 0);

    // Zombie walk to breach.
    align(0);
    step(0, 0, 1, 0);
    check("spawn_gstart", int'(gstart), 1);
    step_ticks(279, 0);
    check("walk_279", int'(gpos), 279);
    check("no_breach_279", int'(breach), 0);
    step_ticks(1, 0);
    check("walk_280", int'(gpos), 280);
    check("breach_set", int'(breach), 1);
    step(0, 0, 1, 0);
    check("spawn_ignored", int'({gpos, gstart}), (280 << 1) | 1);
    for (int i = 0; i < 300; i++) step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    check("breach_held", int'(breach), 1);

    // Collision on the same tick that would otherwise breach.
    do_reset(1);
    align(0);
    step(0, 0, 1, 0);
    step_ticks(253, 0);
    step(0, 1, 0, 1);
    step_ticks(27, 0);
    check("prio_hit", int'(hit), 1);
    check("prio_breach", int'(breach), 0);
    check("prio_gpos", int'(gpos), 279);
    step_ticks(3, 0);

    // Kill sequence with fire held.
    do_reset(1);
    step(0, 0, 1, 1);
    hits = 0; kills = 0;
    for (int i = 0; i < 4000 && kills == 0; i++) begin
      step(0, 1, 0, 1);
      hits += int'(hit);
      kills += int'(kill);
    end
    check("kill_hits", hits, 3);
    check("kill_count", kills, 1);
    check("kill_clear", int'({gstart, gpos}), 0);

    // Random play checked cycle by cycle against the model.
    do_reset(1);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
